// File: rtl/systolic_ctrl.sv
// Control sequencer for an N x N systolic MAC grid: clear, skewed operand feed, drain, done.
// Optional busy-cycle counter output perf_cycles is enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl #(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            abort,
  output logic            busy,
  output logic            mac_clear,
  output logic [N-1:0]    lane_valid,
  output logic [N*KW-1:0] lane_k,
  output logic            done
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_cycles
`endif
);

  localparam int TW = KW + 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [TW-1:0]   r_t;
  logic [TW-1:0]   w_t_nx;
  logic [TW-1:0]   w_t_last;
  logic [KW-1:0]   r_k;
  logic [KW-1:0]   w_k_nx;
  logic [N-1:0]    w_lane_valid_nx;
  logic [N*KW-1:0] w_lane_k_nx;

  assign w_t_last = TW'(r_k) + TW'(N) - TW'(2);

  // next-state and time-counter logic
  always_comb begin
    w_state_nx = r_state;
    w_t_nx     = r_t;
    w_k_nx     = r_k;
    case (r_state)
      S_IDLE: begin
        if (start && (k_len != {KW{1'b0}})) begin
          w_state_nx = S_CLR;
          w_k_nx     = k_len;
          w_t_nx     = {TW{1'b0}};
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_CLR: begin
        w_t_nx = {TW{1'b0}};
        if (abort) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_FEED;
        end
      end
      S_FEED: begin
        if (abort) begin
          w_state_nx = S_IDLE;
          w_t_nx     = {TW{1'b0}};
        end else if (r_t == w_t_last) begin
          w_state_nx = S_DRAIN;
          w_t_nx     = {TW{1'b0}};
        end else begin
          w_t_nx = r_t + TW'(1);
        end
      end
      S_DRAIN: begin
        // r_t is reused to count the N drain cycles
        if (abort) begin
          w_state_nx = S_IDLE;
          w_t_nx     = {TW{1'b0}};
        end else if (r_t == TW'(N - 1)) begin
          w_state_nx = S_FIN;
          w_t_nx     = {TW{1'b0}};
        end else begin
          w_t_nx = r_t + TW'(1);
        end
      end
      S_FIN: begin
        w_state_nx = S_IDLE;
        w_t_nx     = {TW{1'b0}};
      end
      default: begin
        w_state_nx = S_IDLE;
        w_t_nx     = {TW{1'b0}};
      end
    endcase
  end

  // skewed wavefront: lane i is live for t in [i, i+K) with operand index t-i
  always_comb begin
    w_lane_valid_nx = {N{1'b0}};
    w_lane_k_nx     = {(N*KW){1'b0}};
    for (int i = 0; i < N; i++) begin
      if ((w_state_nx == S_FEED) && (w_t_nx >= TW'(i)) &&
          (w_t_nx < (TW'(i) + TW'(r_k)))) begin
        w_lane_valid_nx[i]         = 1'b1;
        w_lane_k_nx[i*KW +: KW]    = KW'(w_t_nx - TW'(i));
      end else begin
        w_lane_valid_nx[i]         = 1'b0;
        w_lane_k_nx[i*KW +: KW]    = {KW{1'b0}};
      end
    end
  end

  // state and registered outputs, decoded from the upcoming state
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_t        <= {TW{1'b0}};
      r_k        <= {KW{1'b0}};
      busy       <= 1'b0;
      mac_clear  <= 1'b0;
      done       <= 1'b0;
      lane_valid <= {N{1'b0}};
      lane_k     <= {(N*KW){1'b0}};
    end else begin
      r_state    <= w_state_nx;
      r_t        <= w_t_nx;
      r_k        <= w_k_nx;
      busy       <= (w_state_nx != S_IDLE);
      mac_clear  <= (w_state_nx == S_CLR);
      done       <= (w_state_nx == S_FIN);
      lane_valid <= w_lane_valid_nx;
      lane_k     <= w_lane_k_nx;
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  // saturating count of busy cycles, cleared only by reset
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      perf_cycles <= 32'd0;
    end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end else begin
      perf_cycles <= perf_cycles;
    end
  end
`else
  // no busy-cycle counter in this build
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl (N=4, KW=8): stimulus queues expected output events,
// a negedge monitor pops and compares every cycle in which the DUT drives a non-zero output.
module tb_systolic_ctrl;
  localparam int TN  = 4;
  localparam int TKW = 8;
  localparam int BIG = 1 << 30;

  logic             clk;
  logic             clear;
  logic             start;
  logic [TKW-1:0]   k_len;
  logic             abort;
  logic             busy;
  logic             mac_clear;
  logic [TN-1:0]    lane_valid;
  logic [TN*TKW-1:0] lane_k;
  logic             done;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]      perf_cycles;
`endif

  systolic_ctrl #(.N(TN), .KW(TKW)) dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .k_len      (k_len),
    .abort      (abort),
    .busy       (busy),
    .mac_clear  (mac_clear),
    .lane_valid (lane_valid),
    .lane_k     (lane_k),
    .done       (done)
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  typedef struct {
    int          cyc;
    logic [3:0]  lv;
    logic [31:0] lk;
    logic        mc;
    logic        dn;
  } ev_t;

  ev_t q[$];
  int  cyc    = 0;
  int  errors = 0;
  int  checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] lv, input logic [31:0] lk,
                      input logic mc, input logic dn);
    ev_t e;
    e.cyc = c; e.lv = lv; e.lk = lk; e.mc = mc; e.dn = dn;
    q.push_back(e);
  endtask

  // expected events of a product started in cycle s, keeping only those up to cycle last
  task automatic push_model(input int s, input int k, input int last);
    logic [3:0]  lv;
    logic [31:0] lk;
    if (s + 1 <= last) push(s + 1, 4'b0000, 32'h0, 1'b1, 1'b0);
    for (int t = 0; t <= k + TN - 2; t++) begin
      lv = 4'b0000;
      lk = 32'h0;
      for (int i = 0; i < TN; i++) begin
        if (t >= i && t < i + k) begin
          lv[i] = 1'b1;
          lk[i*8 +: 8] = 8'(t - i);
        end
      end
      if (s + 2 + t <= last) push(s + 2 + t, lv, lk, 1'b0, 1'b0);
    end
    if (s + k + 2*TN + 1 <= last) push(s + k + 2*TN + 1, 4'b0000, 32'h0, 1'b0, 1'b1);
  endtask

  // monitor: every non-zero output cycle must match the head of the scoreboard
  always @(negedge clk) begin
    ev_t e;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_event: expected at cycle %0d lv=%b lk=%h mc=%b dn=%b, now cycle %0d",
               q[0].cyc, q[0].lv, q[0].lk, q[0].mc, q[0].dn, cyc);
      void'(q.pop_front());
    end
    if (mac_clear || (lane_valid != 4'b0000) || done) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: cycle %0d lv=%b lk=%h mc=%b dn=%b, none expected",
                 cyc, lane_valid, lane_k, mac_clear, done);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.lv !== lane_valid || e.lk !== lane_k ||
            e.mc !== mac_clear || e.dn !== done) begin
          errors++;
          $display("FAIL output_event: got cycle %0d lv=%b lk=%h mc=%b dn=%b, expected cycle %0d lv=%b lk=%h mc=%b dn=%b",
                   cyc, lane_valid, lane_k, mac_clear, done, e.cyc, e.lv, e.lk, e.mc, e.dn);
        end
      end
    end
  end

  initial begin
    int s;
    int s2;
    clear = 1'b1; start = 1'b0; k_len = 8'd0; abort = 1'b0;
    repeat (3) tick();
    chk("reset_busy", busy, 64'd0);
    chk("reset_mac_clear", mac_clear, 64'd0);
    chk("reset_done", done, 64'd0);
    chk("reset_lane_valid", lane_valid, 64'd0);
    chk("reset_lane_k", lane_k, 64'd0);

    // K=3 hand-computed trace; start accepted on first edge after clear release
    clear = 1'b0; start = 1'b1; k_len = 8'd3; s = cyc;
    push(s + 1,  4'b0000, 32'h00000000, 1'b1, 1'b0);
    push(s + 2,  4'b0001, 32'h00000000, 1'b0, 1'b0);
    push(s + 3,  4'b0011, 32'h00000001, 1'b0, 1'b0);
    push(s + 4,  4'b0111, 32'h00000102, 1'b0, 1'b0);
    push(s + 5,  4'b1110, 32'h00010200, 1'b0, 1'b0);
    push(s + 6,  4'b1100, 32'h01020000, 1'b0, 1'b0);
    push(s + 7,  4'b1000, 32'h02000000, 1'b0, 1'b0);
    push(s + 12, 4'b0000, 32'h00000000, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    while (cyc < s + 9) tick();
    chk("drain_busy", busy, 64'd1);
    while (cyc < s + 12) tick();
    start = 1'b1;                      // during FIN: must be ignored
    tick();
    start = 1'b0;
    chk("idle_after_fin", busy, 64'd0);
    tick();
    chk("fin_start_ignored", busy, 64'd0);

    // k_len=0 ignored, then K=1 with abort also high (start wins)
    start = 1'b1; k_len = 8'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("k0_busy", busy, 64'd0);
      tick();
    end
    start = 1'b1; k_len = 8'd1; abort = 1'b1; s = cyc;
    push_model(s, 1, BIG);
    tick();
    start = 1'b0; abort = 1'b0;
    while (cyc < s + 12) tick();

    // abort at t=2 of FEED, then restart one cycle later
    start = 1'b1; k_len = 8'd4; s = cyc;
    push_model(s, 4, s + 4);
    tick();
    start = 1'b0;
    while (cyc < s + 4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 64'd0);
    chk("abort_lane_valid", lane_valid, 64'd0);
    start = 1'b1; k_len = 8'd2; s2 = cyc;
    push_model(s2, 2, BIG);
    tick();
    start = 1'b0;
    while (cyc < s2 + 13) tick();

    // back-to-back K=2 then K=5, second start right after FIN
    start = 1'b1; k_len = 8'd2; s = cyc;
    push_model(s, 2, BIG);
    tick();
    start = 1'b0;
    while (cyc < s + 12) tick();
    start = 1'b1; k_len = 8'd5; s2 = cyc;
    push_model(s2, 5, BIG);
    tick();
    start = 1'b0;
    while (cyc < s2 + 16) tick();

    // clear asserted mid-cycle during DRAIN
    start = 1'b1; k_len = 8'd2; s = cyc;
    push_model(s, 2, s + 7);
    tick();
    start = 1'b0;
    while (cyc < s + 8) tick();
    chk("pre_clear_busy", busy, 64'd1);
    #2 clear = 1'b1;
    #1;
    chk("clear_busy", busy, 64'd0);
    chk("clear_mac_clear", mac_clear, 64'd0);
    chk("clear_done", done, 64'd0);
    chk("clear_lane_valid", lane_valid, 64'd0);
    chk("clear_lane_k", lane_k, 64'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk("clear_perf", perf_cycles, 64'd0);
`endif
    repeat (3) tick();
    clear = 1'b0;
    repeat (15) tick();
    chk("post_clear_busy", busy, 64'd0);
    chk("queue_empty", q.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
